// File: rtl/xdma_cfg_frame_deserializer.sv
// Inbound configuration frame deserializer: decodes the frame-0 header, holds it, and
// emits one normalized payload beat per accepted frame through a single output register.
module xdma_cfg_frame_deserializer #(
  parameter int unsigned AxiWideDataWidth = 512,
  parameter int unsigned TotalFrameWidth  = 4,
  parameter int unsigned DMAIdWidth       = 4,
  parameter int unsigned AddrWidth        = 48,
  parameter int unsigned PayloadWidth     = AxiWideDataWidth - 1 - TotalFrameWidth
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [AxiWideDataWidth-1:0] frame_i,
  input  logic                        frame_valid_i,
  output logic                        frame_ready_o,
  output logic                        dma_type_o,
  output logic [DMAIdWidth-1:0]       dma_id_o,
  output logic [AddrWidth-1:0]        reader_addr_o,
  output logic [AddrWidth-1:0]        writer_addr_o,
  output logic [TotalFrameWidth-1:0]  frame_length_o,
  output logic [PayloadWidth-1:0]     payload_o,
  output logic [TotalFrameWidth-1:0]  payload_idx_o,
  output logic                        payload_first_o,
  output logic                        payload_last_o,
  output logic                        payload_valid_o,
  input  logic                        payload_ready_i,
  output logic                        err_o,
  output logic                        busy_o
);

  localparam int unsigned LenLsb   = 1;
  localparam int unsigned IdLsb    = LenLsb + TotalFrameWidth;
  localparam int unsigned RdLsb    = IdLsb + DMAIdWidth;
  localparam int unsigned WrLsb    = RdLsb + AddrWidth;
  localparam int unsigned HdrWidth = WrLsb + AddrWidth;
  localparam int unsigned BodyLsb  = LenLsb + TotalFrameWidth;

  typedef enum logic [0:0] {StIdle, StBody} state_e;

  state_e                      r_state, w_state_d;
  logic [TotalFrameWidth-1:0]  r_cnt, w_cnt_d;
  logic [TotalFrameWidth-1:0]  r_len, w_len_d;
  logic                        r_type, w_type_d;
  logic [DMAIdWidth-1:0]       r_id, w_id_d;
  logic [AddrWidth-1:0]        r_rd, w_rd_d;
  logic [AddrWidth-1:0]        r_wr, w_wr_d;
  logic                        r_valid, w_valid_d;
  logic [PayloadWidth-1:0]     r_payload, w_payload_d;
  logic [TotalFrameWidth-1:0]  r_idx, w_idx_d;
  logic                        r_first, w_first_d;
  logic                        r_last, w_last_d;
  logic                        r_err, w_err_d;

  logic                        w_accept;
  logic                        w_f_type;
  logic [TotalFrameWidth-1:0]  w_f_len;
  logic                        w_body_last;

  assign frame_ready_o = !r_valid || payload_ready_i;
  assign w_accept      = frame_valid_i && frame_ready_o;
  assign w_f_type      = frame_i[0];
  assign w_f_len       = frame_i[IdLsb-1:LenLsb];
  assign w_body_last   = (r_cnt == r_len - TotalFrameWidth'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_len     <= '0;
      r_type    <= 1'b0;
      r_id      <= '0;
      r_rd      <= '0;
      r_wr      <= '0;
      r_valid   <= 1'b0;
      r_payload <= '0;
      r_idx     <= '0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_len     <= w_len_d;
      r_type    <= w_type_d;
      r_id      <= w_id_d;
      r_rd      <= w_rd_d;
      r_wr      <= w_wr_d;
      r_valid   <= w_valid_d;
      r_payload <= w_payload_d;
      r_idx     <= w_idx_d;
      r_first   <= w_first_d;
      r_last    <= w_last_d;
      r_err     <= w_err_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_len_d     = r_len;
    w_type_d    = r_type;
    w_id_d      = r_id;
    w_rd_d      = r_rd;
    w_wr_d      = r_wr;
    w_valid_d   = r_valid && !payload_ready_i;
    w_payload_d = r_payload;
    w_idx_d     = r_idx;
    w_first_d   = r_first;
    w_last_d    = r_last;
    w_err_d     = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        StIdle: begin
          // A zero-length header cannot describe a cfg: drop it and flag it.
          if (w_f_len == '0) begin
            w_err_d = 1'b1;
          end else begin
            w_type_d    = w_f_type;
            w_len_d     = w_f_len;
            w_id_d      = frame_i[RdLsb-1:IdLsb];
            w_rd_d      = frame_i[WrLsb-1:RdLsb];
            w_wr_d      = frame_i[HdrWidth-1:WrLsb];
            w_valid_d   = 1'b1;
            w_payload_d = PayloadWidth'(frame_i[AxiWideDataWidth-1:HdrWidth]);
            w_idx_d     = '0;
            w_first_d   = 1'b1;
            w_last_d    = (w_f_len == TotalFrameWidth'(1));
            if (w_f_len != TotalFrameWidth'(1)) begin
              w_cnt_d   = TotalFrameWidth'(1);
              w_state_d = StBody;
            end
          end
        end
        StBody: begin
          // Mismatching continuation headers are reported but do not disturb sequencing.
          w_err_d     = (w_f_type != r_type) || (w_f_len != r_len);
          w_valid_d   = 1'b1;
          w_payload_d = frame_i[AxiWideDataWidth-1:BodyLsb];
          w_idx_d     = r_cnt;
          w_first_d   = 1'b0;
          w_last_d    = w_body_last;
          if (w_body_last) begin
            w_cnt_d   = '0;
            w_state_d = StIdle;
          end else begin
            w_cnt_d   = r_cnt + TotalFrameWidth'(1);
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  assign dma_type_o      = r_type;
  assign dma_id_o        = r_id;
  assign reader_addr_o   = r_rd;
  assign writer_addr_o   = r_wr;
  assign frame_length_o  = r_len;
  assign payload_o       = r_payload;
  assign payload_idx_o   = r_idx;
  assign payload_first_o = r_first;
  assign payload_last_o  = r_last;
  assign payload_valid_o = r_valid;
  assign err_o           = r_err;
  assign busy_o          = (r_state == StBody);

endmodule
